mips_multicycle_ctrl: RTL and testbench

Multicycle control FSM that sequences the existing MIPS datapath, one instruction at a time. It accepts an instruction through a valid/ready handshake and holds it in an internal instruction register (IR). It then drives the datapath control inputs (ALUScr, RegWrite, RegDst, MemRead, MemWrite, MemtoReg, ALUControl) phase by phase, so that register-file writes and data-memory accesses occur in dedicated cycles. It also sequences PC update and branch decision and counts retired instructions.

---
 rtl/mips_multicycle_ctrl.sv | 235 +++++++++++++++++++++++
 tb/tb_mips_multicycle_ctrl.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/mips_multicycle_ctrl.sv
// mips_multicycle_ctrl
// Multicycle control FSM for the MIPS datapath. It takes one instruction at a
// time through a valid/ready handshake and latches it into the IR. It then
// steps through DECODE, EXEC, MEM and WB, driving the datapath controls in each
// phase. It also sequences the PC update and branch decision, and counts
// retired instructions.
//
// Ports:
//   clk, rst            rising-edge clock, asynchronous active-low reset
//   instr_valid/ready   instruction handshake (accepted only in FETCH)
//   instruction         instruction word latched into IR on accept
//   Zero, mem_ready     ALU zero flag and data-memory completion from datapath
//   ALUScr .. ALUControl datapath controls, held stable from EXEC through WB
//   ir_out              latched IR, drives the datapath instruction input
//   pc_write            one-cycle PC update pulse, qualified by branch_taken
//   illegal_op          one-cycle pulse on an undecodable instruction
//   mem_error           one-cycle pulse when a memory access times out
//   busy                controller is not in FETCH
//   retired             completed-instruction counter, wraps silently
module mips_multicycle_ctrl #(
  parameter int CNT_W       = 32,
  parameter int MEM_TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             instr_valid,
  input  logic [31:0]      instruction,
  output logic             instr_ready,
  input  logic             Zero,
  input  logic             mem_ready,
  output logic             ALUScr,
  output logic             RegWrite,
  output logic             RegDst,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             MemtoReg,
  output logic [3:0]       ALUControl,
  output logic [31:0]      ir_out,
  output logic             pc_write,
  output logic             branch_taken,
  output logic             illegal_op,
  output logic             mem_error,
  output logic             busy,
  output logic [CNT_W-1:0] retired
);

  localparam int TW = $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB} state_t;
  typedef enum logic [2:0] {
    CLS_NOP, CLS_RTYPE, CLS_LW, CLS_SW, CLS_ADDI, CLS_BEQ, CLS_ILLEGAL
  } cls_t;

  state_t        state;
  logic [TW-1:0] mem_cnt;

  cls_t       dec_cls;
  logic [3:0] dec_alu;
  logic       dec_alusrc;
  logic       dec_regdst;
  logic       dec_memtoreg;
  logic       dest_zero;

  // Accepting is gated by rst so the source sees no ready while reset is held.
  assign instr_ready = (state == FETCH) && rst;
  assign busy        = (state != FETCH);

  // Classify the latched IR. The IR stays stable for the whole instruction,
  // so every later phase can reuse this decode.
  always_comb begin
    dec_cls      = CLS_ILLEGAL;
    dec_alu      = 4'b0000;
    dec_alusrc   = 1'b0;
    dec_regdst   = 1'b0;
    dec_memtoreg = 1'b0;
    if (ir_out == 32'h0) begin
      dec_cls = CLS_NOP;
    end else begin
      case (ir_out[31:26])
        6'b000000: begin
          dec_regdst = 1'b1;
          dec_cls    = CLS_RTYPE;
          case (ir_out[5:0])
            6'b100000: dec_alu = 4'b0010;
            6'b100010: dec_alu = 4'b0110;
            6'b100100: dec_alu = 4'b0000;
            6'b100101: dec_alu = 4'b0001;
            6'b101010: dec_alu = 4'b0111;
            default:   dec_cls = CLS_ILLEGAL;
          endcase
        end
        6'b100011: begin
          dec_cls      = CLS_LW;
          dec_alu      = 4'b0010;
          dec_alusrc   = 1'b1;
          dec_memtoreg = 1'b1;
        end
        6'b101011: begin
          dec_cls    = CLS_SW;
          dec_alu    = 4'b0010;
          dec_alusrc = 1'b1;
        end
        6'b001000: begin
          dec_cls    = CLS_ADDI;
          dec_alu    = 4'b0010;
          dec_alusrc = 1'b1;
        end
        6'b000100: begin
          dec_cls = CLS_BEQ;
          dec_alu = 4'b0110;
        end
        default: dec_cls = CLS_ILLEGAL;
      endcase
    end
  end

  // A write to $0 is dropped here, so the register file never sees one.
  assign dest_zero = dec_regdst ? (ir_out[15:11] == 5'd0) : (ir_out[20:16] == 5'd0);

  // Main sequencer. Every output is registered on the transition into the
  // cycle where it applies. Pulses default low each cycle. The datapath
  // controls are cleared whenever the FSM returns to FETCH.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= FETCH;
      ir_out       <= '0;
      mem_cnt      <= '0;
      retired      <= '0;
      ALUScr       <= 1'b0;
      RegWrite     <= 1'b0;
      RegDst       <= 1'b0;
      MemRead      <= 1'b0;
      MemWrite     <= 1'b0;
      MemtoReg     <= 1'b0;
      ALUControl   <= 4'b0000;
      pc_write     <= 1'b0;
      branch_taken <= 1'b0;
      illegal_op   <= 1'b0;
      mem_error    <= 1'b0;
    end else begin
      pc_write     <= 1'b0;
      branch_taken <= 1'b0;
      illegal_op   <= 1'b0;
      mem_error    <= 1'b0;
      RegWrite     <= 1'b0;
      case (state)
        FETCH: begin
          if (instr_valid) begin
            ir_out <= instruction;
            state  <= DECODE;
          end
        end
        DECODE: begin
          case (dec_cls)
            CLS_NOP: begin
              pc_write <= 1'b1;
              retired  <= retired + CNT_W'(1);
              state    <= FETCH;
            end
            CLS_ILLEGAL: begin
              illegal_op <= 1'b1;
              pc_write   <= 1'b1;
              state      <= FETCH;
            end
            default: begin
              ALUScr     <= dec_alusrc;
              ALUControl <= dec_alu;
              RegDst     <= dec_regdst;
              MemtoReg   <= dec_memtoreg;
              state      <= EXEC;
            end
          endcase
        end
        EXEC: begin
          case (dec_cls)
            CLS_BEQ: begin
              pc_write     <= 1'b1;
              branch_taken <= Zero;
              retired      <= retired + CNT_W'(1);
              {ALUScr, RegDst, MemtoReg, ALUControl} <= '0;
              state        <= FETCH;
            end
            CLS_LW: begin
              MemRead <= 1'b1;
              mem_cnt <= '0;
              state   <= MEM;
            end
            CLS_SW: begin
              MemWrite <= 1'b1;
              mem_cnt  <= '0;
              state    <= MEM;
            end
            default: begin
              RegWrite <= !dest_zero;
              state    <= WB;
            end
          endcase
        end
        MEM: begin
          // A mem_ready in the final allowed cycle wins over the timeout.
          if (mem_ready) begin
            MemRead  <= 1'b0;
            MemWrite <= 1'b0;
            if (dec_cls == CLS_LW) begin
              RegWrite <= !dest_zero;
              state    <= WB;
            end else begin
              pc_write <= 1'b1;
              retired  <= retired + CNT_W'(1);
              {ALUScr, RegDst, MemtoReg, ALUControl} <= '0;
              state    <= FETCH;
            end
          end else if (mem_cnt == TW'(MEM_TIMEOUT - 1)) begin
            MemRead   <= 1'b0;
            MemWrite  <= 1'b0;
            mem_error <= 1'b1;
            pc_write  <= 1'b1;
            {ALUScr, RegDst, MemtoReg, ALUControl} <= '0;
            state     <= FETCH;
          end else begin
            mem_cnt <= mem_cnt + TW'(1);
          end
        end
        WB: begin
          pc_write <= 1'b1;
          retired  <= retired + CNT_W'(1);
          {ALUScr, RegDst, MemtoReg, ALUControl} <= '0;
          state    <= FETCH;
        end
        default: state <= FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// tb_mips_multicycle_ctrl
// Directed testbench for mips_multicycle_ctrl. Each scenario task issues an
// instruction and records a per-cycle trace of the controller outputs
// (cycle 1 = the first cycle after the accept edge). It then compares the
// trace against hand-computed timing.
module tb_mips_multicycle_ctrl;

  logic        clk;
  logic        rst;
  logic        instr_valid;
  logic [31:0] instruction;
  logic        instr_ready;
  logic        zero_flag;
  logic        mem_ready;
  logic        alu_src;
  logic        reg_write;
  logic        reg_dst;
  logic        mem_read;
  logic        mem_write;
  logic        mem_to_reg;
  logic [3:0]  alu_control;
  logic [31:0] ir_out;
  logic        pc_write;
  logic        branch_taken;
  logic        illegal_op;
  logic        mem_error;
  logic        busy;
  logic [31:0] retired;

  int checks = 0;
  int passed = 0;
  logic [31:0] exp_retired;

  // Per-cycle traces, bit/index c = cycle c after the accept edge.
  logic [31:0] pcw_t, rw_t, mr_t, mw_t, bt_t, ill_t, merr_t, rdy_t, rdst_t, m2r_t, asrc_t;
  logic [3:0]  alu_t [0:31];

  mips_multicycle_ctrl #(.CNT_W(32), .MEM_TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .instruction(instruction),
    .instr_ready(instr_ready), .Zero(zero_flag), .mem_ready(mem_ready),
    .ALUScr(alu_src), .RegWrite(reg_write), .RegDst(reg_dst), .MemRead(mem_read),
    .MemWrite(mem_write), .MemtoReg(mem_to_reg), .ALUControl(alu_control),
    .ir_out(ir_out), .pc_write(pc_write), .branch_taken(branch_taken),
    .illegal_op(illegal_op), .mem_error(mem_error), .busy(busy), .retired(retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  function automatic int first_set(input logic [31:0] v);
    for (int i = 0; i < 32; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one instruction from FETCH and trace n cycles. mem_ready is high
  // only in cycle ready_cyc (0 = never); Zero is held at zero_val throughout.
  task automatic run_instr(input logic [31:0] word, input int n, input int ready_cyc,
                           input logic zero_val);
    pcw_t = '0; rw_t = '0; mr_t = '0; mw_t = '0; bt_t = '0; ill_t = '0;
    merr_t = '0; rdy_t = '0; rdst_t = '0; m2r_t = '0; asrc_t = '0;
    for (int i = 0; i < 32; i++) alu_t[i] = 4'h0;
    zero_flag   = zero_val;
    instruction = word;
    instr_valid = 1'b1;
    for (int c = 1; c <= n; c++) begin
      step();
      instr_valid = 1'b0;
      mem_ready   = (c == ready_cyc);
      pcw_t[c] = pc_write;   rw_t[c] = reg_write;  mr_t[c] = mem_read;
      mw_t[c] = mem_write;   bt_t[c] = branch_taken; ill_t[c] = illegal_op;
      merr_t[c] = mem_error; rdy_t[c] = instr_ready; rdst_t[c] = reg_dst;
      m2r_t[c] = mem_to_reg; asrc_t[c] = alu_src;  alu_t[c] = alu_control;
    end
    mem_ready = 1'b0;
  endtask

  task automatic test_reset();
    logic [14:0] outs;
    rst = 1'b0; instr_valid = 1'b0; instruction = '0; zero_flag = 1'b0; mem_ready = 1'b0;
    step(); step();
    outs = {alu_src, reg_write, reg_dst, mem_read, mem_write, mem_to_reg, alu_control,
            pc_write, branch_taken, illegal_op, mem_error, busy};
    checks++; if (outs !== 15'h0) $display("[TB] FAIL reset_outputs: got %h expected 0", outs); else passed++;
    checks++; if (instr_ready !== 1'b0) $display("[TB] FAIL reset_ready: got %b expected 0", instr_ready); else passed++;
    checks++; if (retired !== 32'd0 || ir_out !== 32'd0) $display("[TB] FAIL reset_regs: retired %0d ir %h expected 0 0", retired, ir_out); else passed++;
    rst = 1'b1;
    #1;
    checks++; if (instr_ready !== 1'b1) $display("[TB] FAIL release_ready: got %b expected 1", instr_ready); else passed++;
    step();
    // ADD, then reset while it is in EXEC.
    instruction = 32'h02324820; instr_valid = 1'b1;
    step(); instr_valid = 1'b0;
    step();
    checks++; if (alu_control !== 4'b0010 || busy !== 1'b1) $display("[TB] FAIL exec_before_reset: alu %b busy %b expected 0010 1", alu_control, busy); else passed++;
    rst = 1'b0;
    #1;
    outs = {alu_src, reg_write, reg_dst, mem_read, mem_write, mem_to_reg, alu_control,
            pc_write, branch_taken, illegal_op, mem_error, busy};
    checks++; if (outs !== 15'h0 || ir_out !== 32'd0) $display("[TB] FAIL midexec_reset: outs %h ir %h expected 0 0", outs, ir_out); else passed++;
    step(); step();
    rst = 1'b1;
    #1;
    checks++; if (instr_ready !== 1'b1 || busy !== 1'b0) $display("[TB] FAIL midexec_release: ready %b busy %b expected 1 0", instr_ready, busy); else passed++;
    pcw_t = '0; rw_t = '0;
    for (int c = 0; c < 4; c++) begin
      step();
      pcw_t[c] = pc_write; rw_t[c] = reg_write;
    end
    checks++; if (pcw_t !== 32'h0 || rw_t !== 32'h0 || retired !== 32'd0) $display("[TB] FAIL aborted_no_retire: pcw %h rw %h retired %0d expected 0 0 0", pcw_t, rw_t, retired); else passed++;
    exp_retired = 32'd0;
  endtask

  task automatic test_lw();
    run_instr(32'h8C080005, 10, 5, 1'b0);
    exp_retired = exp_retired + 1;
    checks++; if ($countones(mr_t) !== 3 || first_set(mr_t) !== 3) $display("[TB] FAIL lw_memread: count %0d first %0d expected 3 3", $countones(mr_t), first_set(mr_t)); else passed++;
    checks++; if (alu_t[2] !== 4'b0010 || asrc_t[2] !== 1'b1) $display("[TB] FAIL lw_exec_ctrl: alu %b src %b expected 0010 1", alu_t[2], asrc_t[2]); else passed++;
    checks++; if (rw_t !== 32'h1 << 6) $display("[TB] FAIL lw_regwrite: trace %h expected %h", rw_t, 32'h1 << 6); else passed++;
    checks++; if (rdst_t[6] !== 1'b0 || m2r_t[6] !== 1'b1) $display("[TB] FAIL lw_wb_ctrl: regdst %b memtoreg %b expected 0 1", rdst_t[6], m2r_t[6]); else passed++;
    checks++; if (pcw_t !== 32'h1 << 7) $display("[TB] FAIL lw_pc_write: trace %h expected %h", pcw_t, 32'h1 << 7); else passed++;
    checks++; if (retired !== exp_retired) $display("[TB] FAIL lw_retired: got %0d expected %0d", retired, exp_retired); else passed++;
  endtask

  task automatic test_add_sub();
    logic [31:0] words [2];
    logic [3:0]  alus  [2];
    words[0] = 32'h02324820; alus[0] = 4'b0010;
    words[1] = 32'h02325022; alus[1] = 4'b0110;
    for (int k = 0; k < 2; k++) begin
      run_instr(words[k], 6, 0, 1'b0);
      exp_retired = exp_retired + 1;
      checks++; if (alu_t[2] !== alus[k] || alu_t[3] !== alus[k]) $display("[TB] FAIL rtype%0d_alu: exec %b wb %b expected %b", k, alu_t[2], alu_t[3], alus[k]); else passed++;
      checks++; if (rdst_t[3] !== 1'b1 || asrc_t[2] !== 1'b0) $display("[TB] FAIL rtype%0d_ctrl: regdst %b src %b expected 1 0", k, rdst_t[3], asrc_t[2]); else passed++;
      checks++; if (rw_t !== 32'h1 << 3) $display("[TB] FAIL rtype%0d_regwrite: trace %h expected %h", k, rw_t, 32'h1 << 3); else passed++;
      checks++; if (pcw_t !== 32'h1 << 4) $display("[TB] FAIL rtype%0d_pc_write: trace %h expected %h", k, pcw_t, 32'h1 << 4); else passed++;
      checks++; if (rdy_t[3:1] !== 3'b000 || rdy_t[4] !== 1'b1) $display("[TB] FAIL rtype%0d_ready: trace %h expected ready only from cycle 4", k, rdy_t); else passed++;
    end
    checks++; if (retired !== exp_retired) $display("[TB] FAIL add_sub_retired: got %0d expected %0d", retired, exp_retired); else passed++;
  endtask

  task automatic test_beq();
    for (int k = 0; k < 2; k++) begin
      run_instr(32'h12320003, 5, 0, (k == 0));
      exp_retired = exp_retired + 1;
      checks++; if (pcw_t !== 32'h1 << 3) $display("[TB] FAIL beq%0d_pc_write: trace %h expected %h", k, pcw_t, 32'h1 << 3); else passed++;
      checks++; if (bt_t !== ((k == 0) ? (32'h1 << 3) : 32'h0)) $display("[TB] FAIL beq%0d_taken: trace %h expected %h", k, bt_t, (k == 0) ? (32'h1 << 3) : 32'h0); else passed++;
      checks++; if (alu_t[2] !== 4'b0110 || asrc_t[2] !== 1'b0) $display("[TB] FAIL beq%0d_exec_ctrl: alu %b src %b expected 0110 0", k, alu_t[2], asrc_t[2]); else passed++;
      checks++; if ((rw_t | mr_t | mw_t) !== 32'h0) $display("[TB] FAIL beq%0d_no_side_effects: rw %h mr %h mw %h expected 0", k, rw_t, mr_t, mw_t); else passed++;
    end
    checks++; if (retired !== exp_retired) $display("[TB] FAIL beq_retired: got %0d expected %0d", retired, exp_retired); else passed++;
  endtask

  task automatic test_sw_timeout();
    run_instr(32'hAC080005, 22, 0, 1'b0);
    checks++; if ($countones(mw_t) !== 16 || first_set(mw_t) !== 3) $display("[TB] FAIL sw_to_memwrite: count %0d first %0d expected 16 3", $countones(mw_t), first_set(mw_t)); else passed++;
    checks++; if (merr_t !== 32'h1 << 19) $display("[TB] FAIL sw_to_mem_error: trace %h expected %h", merr_t, 32'h1 << 19); else passed++;
    checks++; if (pcw_t !== 32'h1 << 19) $display("[TB] FAIL sw_to_pc_write: trace %h expected %h", pcw_t, 32'h1 << 19); else passed++;
    checks++; if (retired !== exp_retired) $display("[TB] FAIL sw_to_retired: got %0d expected %0d", retired, exp_retired); else passed++;
    // mem_ready arriving in the last allowed MEM cycle is a success.
    run_instr(32'hAC080005, 22, 18, 1'b0);
    exp_retired = exp_retired + 1;
    checks++; if (merr_t !== 32'h0 || pcw_t !== 32'h1 << 19) $display("[TB] FAIL sw_late_ready: merr %h pcw %h expected 0 %h", merr_t, pcw_t, 32'h1 << 19); else passed++;
    checks++; if ($countones(mw_t) !== 16 || retired !== exp_retired) $display("[TB] FAIL sw_late_retire: memwrite %0d retired %0d expected 16 %0d", $countones(mw_t), retired, exp_retired); else passed++;
  endtask

  task automatic test_illegal_nop();
    run_instr(32'h0232482F, 4, 0, 1'b0);
    checks++; if (ill_t !== 32'h1 << 2 || pcw_t !== 32'h1 << 2) $display("[TB] FAIL illegal_pulse: ill %h pcw %h expected %h %h", ill_t, pcw_t, 32'h1 << 2, 32'h1 << 2); else passed++;
    checks++; if (rw_t !== 32'h0 || retired !== exp_retired) $display("[TB] FAIL illegal_no_retire: rw %h retired %0d expected 0 %0d", rw_t, retired, exp_retired); else passed++;
    run_instr(32'h00000000, 4, 0, 1'b0);
    exp_retired = exp_retired + 1;
    checks++; if (ill_t !== 32'h0 || pcw_t !== 32'h1 << 2) $display("[TB] FAIL nop_timing: ill %h pcw %h expected 0 %h", ill_t, pcw_t, 32'h1 << 2); else passed++;
    checks++; if (retired !== exp_retired) $display("[TB] FAIL nop_retired: got %0d expected %0d", retired, exp_retired); else passed++;
    run_instr(32'h02320020, 6, 0, 1'b0);
    exp_retired = exp_retired + 1;
    checks++; if (rw_t !== 32'h0 || pcw_t !== 32'h1 << 4) $display("[TB] FAIL add_r0: rw %h pcw %h expected 0 %h", rw_t, pcw_t, 32'h1 << 4); else passed++;
    checks++; if (retired !== exp_retired) $display("[TB] FAIL add_r0_retired: got %0d expected %0d", retired, exp_retired); else passed++;
  endtask

  initial begin
    test_reset();
    test_lw();
    test_add_sub();
    test_beq();
    test_sw_timeout();
    test_illegal_nop();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
